// File: rtl/key_event_if.sv
// -----------------------------------------------------------------------------
// key_event_if
// Bundle between the debounced key detector and the gesture classifier.
//   press_down, press_up : one-cycle pulses from the debouncer
//   short_click, double_click, long_press, long_release, key_repeat :
//                          one-cycle gesture pulses from the classifier
//   key_held             : level, key currently down
// Modports:
//   master : stimulus side (drives the press pulses, observes the events)
//   slave  : classifier side
// -----------------------------------------------------------------------------
interface key_event_if;
  logic press_down;
  logic press_up;
  logic short_click;
  logic double_click;
  logic long_press;
  logic long_release;
  logic key_held;
  logic key_repeat;

  modport master (
    output press_down, press_up,
    input  short_click, double_click, long_press, long_release, key_held, key_repeat
  );

  modport slave (
    input  press_down, press_up,
    output short_click, double_click, long_press, long_release, key_held, key_repeat
  );
endinterface

// File: rtl/key_event_classifier.sv
// -----------------------------------------------------------------------------
// key_event_classifier
// Turns debounced press/release pulses of one key into gesture events:
// short click, double click, long press, long release, plus a key_held level.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   kif  : key_event_if.slave
//            in : press_down, press_up (one-cycle pulses)
//            out: short_click, double_click, long_press, long_release,
//                 key_repeat (one-cycle pulses), key_held (level)
//
// Parameters:
//   LONG_CNT   : cycles a press must last to become a long press
//   DCLICK_CNT : window after a release in which a second press is a double click
//   REPEAT_CNT : auto-repeat period while long-held (KEY_REPEAT_EN only)
//   CNT_W      : interval counter width
//
// Build option:
//   KEY_REPEAT_EN : when defined, key_repeat pulses every REPEAT_CNT cycles
//                   while long-held; otherwise key_repeat is tied to 0 and
//                   the counter is frozen in LONG_HELD.
// -----------------------------------------------------------------------------
module key_event_classifier #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  kif
);

  // Every interval must be reachable by the counter (it compares against N-1).
  if (LONG_CNT < 1 || DCLICK_CNT < 1 || REPEAT_CNT < 1 ||
      longint'(LONG_CNT)   > (longint'(1) << CNT_W) ||
      longint'(DCLICK_CNT) > (longint'(1) << CNT_W) ||
      longint'(REPEAT_CNT) > (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("key_event_classifier: interval counts do not fit CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT2,
    S_PRESSED2,
    S_LONG_HELD
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             short_click_q, short_click_d;
  logic             double_click_q, double_click_d;
  logic             long_press_q, long_press_d;
  logic             long_release_q, long_release_d;
  logic             key_held_q, key_held_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
  logic             repeat_q, repeat_d;
`endif

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_inc;
    short_click_d  = 1'b0;
    double_click_d = 1'b0;
    long_press_d   = 1'b0;
    long_release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d       = 1'b0;
`endif

    // Press-type states look at press_up first, the others at press_down,
    // which also resolves both pulses arriving together.
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (kif.press_down) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (kif.press_up) begin
          state_d = S_WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = S_LONG_HELD;
          long_press_d = 1'b1;
        end
      end
      S_WAIT2: begin
        if (kif.press_down) begin
          state_d = S_PRESSED2;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d       = S_IDLE;
          short_click_d = 1'b1;
        end
      end
      S_PRESSED2: begin
        if (kif.press_up) begin
          state_d        = S_IDLE;
          double_click_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          // The pending first click is dropped in favour of the long press.
          state_d      = S_LONG_HELD;
          long_press_d = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (kif.press_up) begin
          state_d        = S_IDLE;
          long_release_d = 1'b1;
        end else begin
`ifdef KEY_REPEAT_EN
          if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    key_held_d = (state_d == S_PRESSED) || (state_d == S_PRESSED2) ||
                 (state_d == S_LONG_HELD);
  end

  // NOTE: the reset is synchronous (sampled only on the clock edge) and all
  // state updates use non-blocking assignments so every flop sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      short_click_q  <= 1'b0;
      double_click_q <= 1'b0;
      long_press_q   <= 1'b0;
      long_release_q <= 1'b0;
      key_held_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      short_click_q  <= short_click_d;
      double_click_q <= double_click_d;
      long_press_q   <= long_press_d;
      long_release_q <= long_release_d;
      key_held_q     <= key_held_d;
`ifdef KEY_REPEAT_EN
      repeat_q       <= repeat_d;
`endif
    end
  end

  assign kif.short_click  = short_click_q;
  assign kif.double_click = double_click_q;
  assign kif.long_press   = long_press_q;
  assign kif.long_release = long_release_q;
  assign kif.key_held     = key_held_q;
`ifdef KEY_REPEAT_EN
  assign kif.key_repeat   = repeat_q;
`else
  assign kif.key_repeat   = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_classifier.sv
// -----------------------------------------------------------------------------
// tb_key_event_classifier
// Directed scenarios plus randomized press/release traffic. A timestamp-based
// gesture model predicts the six outputs after every edge; a negedge process
// compares them, and directed scenarios pin absolute pulse timing with
// hand-computed edge offsets.
// -----------------------------------------------------------------------------
module tb_key_event_classifier;

  localparam int LONG_CNT   = 20;
  localparam int DCLICK_CNT = 8;
  localparam int REPEAT_CNT = 5;
  localparam int CNT_W      = 5;

  logic clk;
  logic rst;
  key_event_if kif ();

  key_event_classifier #(
    .LONG_CNT  (LONG_CNT),
    .DCLICK_CNT(DCLICK_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: gesture phase plus the edge at which it was entered.
  // Thresholds are expressed as elapsed edges since entry.
  // ---------------------------------------------------------------------------
  typedef enum {PH_IDLE, PH_DOWN1, PH_GAP, PH_DOWN2, PH_LONG} phase_e;

  phase_e ph = PH_IDLE;
  int     t_mark = 0;
  int     edge_cnt = 0;
  bit     started = 0;
  bit     exp_short, exp_double, exp_lpress, exp_lrel, exp_held, exp_rep;

  always @(posedge clk) begin
    int     el;
    bit     dn, up;
    phase_e nx;
    edge_cnt++;
    dn = kif.press_down;
    up = kif.press_up;
    exp_short = 0; exp_double = 0; exp_lpress = 0; exp_lrel = 0; exp_rep = 0;
    if (rst) begin
      ph      = PH_IDLE;
      t_mark  = edge_cnt;
      started = 1;
    end else begin
      el = edge_cnt - t_mark;
      nx = ph;
      case (ph)
        PH_IDLE:  if (dn) nx = PH_DOWN1;
        PH_DOWN1: if (up) nx = PH_GAP;
                  else if (el == LONG_CNT) begin nx = PH_LONG; exp_lpress = 1; end
        PH_GAP:   if (dn) nx = PH_DOWN2;
                  else if (el == DCLICK_CNT) begin nx = PH_IDLE; exp_short = 1; end
        PH_DOWN2: if (up) begin nx = PH_IDLE; exp_double = 1; end
                  else if (el == LONG_CNT) begin nx = PH_LONG; exp_lpress = 1; end
        PH_LONG:  if (up) begin nx = PH_IDLE; exp_lrel = 1; end
`ifdef KEY_REPEAT_EN
                  else if (el == REPEAT_CNT) begin exp_rep = 1; t_mark = edge_cnt; end
`endif
        default:  nx = PH_IDLE;
      endcase
      if (nx != ph) begin
        ph     = nx;
        t_mark = edge_cnt;
      end
    end
    exp_held = (ph == PH_DOWN1) || (ph == PH_DOWN2) || (ph == PH_LONG);
  end

  // ---------------------------------------------------------------------------
  // Compare and event log, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  int tot_short = 0, tot_double = 0, tot_lpress = 0, tot_lrel = 0, tot_rep = 0, tot_held = 0;
  int last_short = -1, last_double = -1, last_lpress = -1, last_lrel = -1;

  always @(negedge clk) begin
    int pulses;
    if (started) begin
      check("outputs",
            int'({kif.short_click, kif.double_click, kif.long_press,
                  kif.long_release, kif.key_held, kif.key_repeat}),
            int'({exp_short, exp_double, exp_lpress, exp_lrel, exp_held, exp_rep}));
      pulses = int'(kif.short_click) + int'(kif.double_click) + int'(kif.long_press) +
               int'(kif.long_release) + int'(kif.key_repeat);
      check("one_pulse_max", int'(pulses <= 1), 1);
      if (kif.short_click  === 1'b1) begin tot_short++;  last_short  = edge_cnt; end
      if (kif.double_click === 1'b1) begin tot_double++; last_double = edge_cnt; end
      if (kif.long_press   === 1'b1) begin tot_lpress++; last_lpress = edge_cnt; end
      if (kif.long_release === 1'b1) begin tot_lrel++;   last_lrel   = edge_cnt; end
      if (kif.key_repeat   === 1'b1) tot_rep++;
      if (kif.key_held     === 1'b1) tot_held++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All run from a falling edge and return on one.
  // ---------------------------------------------------------------------------
  int s_short, s_double, s_lpress, s_lrel, s_rep, s_held;

  task automatic snap();
    s_short = tot_short; s_double = tot_double; s_lpress = tot_lpress;
    s_lrel = tot_lrel; s_rep = tot_rep; s_held = tot_held;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle pulse; e is the edge that samples it.
  task automatic pulse(input bit dn, input bit up, output int e);
    kif.press_down = dn;
    kif.press_up   = up;
    e = edge_cnt + 1;
    @(negedge clk);
    kif.press_down = 1'b0;
    kif.press_up   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({kif.short_click, kif.double_click, kif.long_press,
                      kif.long_release, kif.key_held, kif.key_repeat}), 0);
  endtask

  int e0, e1, e2, e3, ed;

  initial begin
    rst = 1'b1;
    kif.press_down = 1'b0;
    kif.press_up   = 1'b0;
    idle(2);
    rst = 1'b0;
    check_all_zero("reset_state");

    // 1: short click
    snap();
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(12);
    check("s1_up_offset", e1 - e0, 5);
    check("s1_short_cnt", tot_short - s_short, 1);
    check("s1_short_edge", last_short - e1, 8);
    check("s1_other_pulses", (tot_double - s_double) + (tot_lpress - s_lpress) + (tot_lrel - s_lrel), 0);
    check("s1_held_cycles", tot_held - s_held, 5);

    // 2: double click
    snap();
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(2); pulse(1, 0, e2); idle(3); pulse(0, 1, e3); idle(12);
    check("s2_double_cnt", tot_double - s_double, 1);
    check("s2_double_edge", last_double, e3);
    check("s2_no_short", tot_short - s_short, 0);

    // 3: long press, release at +30
    snap();
    pulse(1, 0, e0); idle(29); pulse(0, 1, e1); idle(12);
    check("s3_lpress_edge", last_lpress - e0, 20);
    check("s3_lrel_edge", last_lrel, e1);
    check("s3_lrel_cnt", tot_lrel - s_lrel, 1);
    check("s3_no_short", tot_short - s_short, 0);
`ifdef KEY_REPEAT_EN
    check("s3_repeat_cnt", tot_rep - s_rep, 1);
`else
    check("s3_repeat_cnt", tot_rep - s_rep, 0);
`endif

    // 4a: release exactly on the long threshold edge
    snap();
    pulse(1, 0, e0); idle(19); pulse(0, 1, e1); idle(12);
    check("s4a_up_offset", e1 - e0, 20);
    check("s4a_no_lpress", tot_lpress - s_lpress, 0);
    check("s4a_short_edge", last_short - e1, 8);

    // 4b: second press exactly on the double-click timeout edge
    snap();
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(7); pulse(1, 0, e2); idle(2); pulse(0, 1, e3); idle(12);
    check("s4b_dn_offset", e2 - e1, 8);
    check("s4b_no_short", tot_short - s_short, 0);
    check("s4b_double_edge", last_double, e3);

    // 5a: reset while waiting for a second press
    snap();
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(2); do_reset();
    check_all_zero("s5a_after_rst");
    idle(12);
    check("s5a_no_short", tot_short - s_short, 0);
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(12);
    check("s5a_short_edge", last_short - e1, 8);

    // 5b: reset while long-held
    snap();
    pulse(1, 0, e0); idle(24); do_reset();
    check_all_zero("s5b_after_rst");
    pulse(0, 1, ed); idle(10);
    check("s5b_no_lrel", tot_lrel - s_lrel, 0);
    pulse(1, 0, e0); idle(4); pulse(0, 1, e1); idle(12);
    check("s5b_short_edge", last_short - e1, 8);

    // 6: stray release in IDLE, duplicate press while pressed
    snap();
    pulse(0, 1, ed); idle(2);
    pulse(1, 0, e0); idle(1); pulse(1, 0, ed); idle(2); pulse(0, 1, e1); idle(12);
    check("s6_up_offset", e1 - e0, 5);
    check("s6_short_cnt", tot_short - s_short, 1);
    check("s6_short_edge", last_short - e1, 8);

    // Randomized traffic, including simultaneous pulses and long gaps.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      pulse(r < 45, r >= 35, ed);
      idle(int'($urandom_range(0, 26)));
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
